// File: rtl/norm_pkg.sv
// Shared types and constants for the iterative normalising shifter.
// Holds the FSM state type, direction codes and the default data width.
package norm_pkg;

    localparam int NORM_WIDTH = 32;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Width of the stage index: enough to hold $clog2(width)-1, min 1.
    function automatic int stg_w(input int width);
        int stages;
        stages = $clog2(width);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/norm_shifter_if.sv
// Handshake bundle for norm_shifter: input word side and result side.
// master = upstream/downstream driver, slave = the normaliser itself.
interface norm_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic             dir;
    logic [WIDTH-1:0] data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] shift_cnt;
    logic             zero;

    modport master (
        output in_valid, dir, data, out_ready,
        input  in_ready, out_valid, out_data, shift_cnt, zero
    );

    modport slave (
        input  in_valid, dir, data, out_ready,
        output in_ready, out_valid, out_data, shift_cnt, zero
    );

endinterface

// File: rtl/norm_step.sv
// One normalisation stage: tests a 2^stage wide edge field for zero and
// shifts it out. Ports: i_work/i_dir/i_stage in, o_next_work/o_add_amt out.
module norm_step
    import norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1,
    localparam int STG_W = stg_w(WIDTH)
) (
    input  logic [WIDTH-1:0] i_work,
    input  logic             i_dir,
    input  logic [STG_W-1:0] i_stage,
    output logic [WIDTH-1:0] o_next_work,
    output logic [CNT_W-1:0] o_add_amt
);

    logic [CNT_W-1:0] w_step;
    logic [WIDTH-1:0] w_hi_mask;
    logic [WIDTH-1:0] w_lo_mask;
    logic             w_field_zero;

    // Masks select the top / bottom `step` bits of the work word.
    assign w_step    = CNT_W'(1) << i_stage;
    assign w_hi_mask = ~({WIDTH{1'b1}} >> w_step);
    assign w_lo_mask = ~({WIDTH{1'b1}} << w_step);

    assign w_field_zero = (i_dir == DIR_LEFT)
                        ? ((i_work & w_hi_mask) == '0)
                        : ((i_work & w_lo_mask) == '0);

    always_comb begin
        o_next_work = i_work;
        o_add_amt   = '0;
        if (w_field_zero) begin
            o_add_amt = w_step;
            if (i_dir == DIR_LEFT) begin
                o_next_work = i_work << w_step;
            end else begin
                o_next_work = i_work >> w_step;
            end
        end
    end

endmodule

// File: rtl/norm_shifter.sv
// Iterative normaliser: recovers the shift amount that left/right aligns a
// word. Ports: clk, rst_n (sync, active low), bus (norm_shifter_if.slave).
module norm_shifter
    import norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    norm_shifter_if.slave bus
);

    localparam int STAGES = $clog2(WIDTH);
    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int STG_W  = stg_w(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero_in;
    logic [STG_W-1:0] r_stage;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_shift_cnt;
    logic             r_zero;

    logic [WIDTH-1:0] w_next_work;
    logic [CNT_W-1:0] w_add_amt;

    norm_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_work      (r_work),
        .i_dir       (r_dir),
        .i_stage     (r_stage),
        .o_next_work (w_next_work),
        .o_add_amt   (w_add_amt)
    );

    // DONE spends its first cycle loading the output registers, which
    // makes the result appear STAGES+1 clocks after accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_dir       <= DIR_LEFT;
            r_cnt       <= '0;
            r_zero_in   <= 1'b0;
            r_stage     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_shift_cnt <= '0;
            r_zero      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_work     <= bus.data;
                        r_dir      <= bus.dir;
                        r_cnt      <= '0;
                        r_zero_in  <= (bus.data == '0);
                        r_stage    <= STG_W'(STAGES - 1);
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= w_next_work;
                    r_cnt  <= r_cnt + w_add_amt;
                    if (r_stage == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_stage <= r_stage - 1'b1;
                    end
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_work;
                        r_zero      <= r_zero_in;
                        // Zero input walks every stage to WIDTH-1.
                        r_shift_cnt <= r_zero_in ? CNT_W'(WIDTH)
                                                 : r_cnt;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_shift_cnt <= '0;
                        r_zero      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.shift_cnt = r_shift_cnt;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_norm_shifter.sv
// Directed and randomised bench for norm_shifter against a bit-loop
// reference model of leading/trailing zero normalisation.
module tb_norm_shifter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    norm_shifter_if #(.WIDTH(32)) nif ();

    norm_shifter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (nif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk bit by bit until the chosen edge bit is set.
    task automatic model(input logic d, input logic [31:0] x,
                         output logic [31:0] od, output int c,
                         output logic z);
        od = x;
        c  = 0;
        z  = (x == 0);
        if (z) begin
            c = 32;
        end else if (d == 1'b0) begin
            while (od[31] == 1'b0) begin
                od = od << 1;
                c++;
            end
        end else begin
            while (od[0] == 1'b0) begin
                od = od >> 1;
                c++;
            end
        end
    endtask

    task automatic start(input logic d, input logic [31:0] x);
        int k;
        k = 0;
        nif.in_valid = 1'b1;
        nif.dir      = d;
        nif.data     = x;
        while (!nif.in_ready && k < 50) begin
            tick();
            k++;
        end
        chk("accept_ready", 64'(nif.in_ready), 64'd1);
        tick();
        nif.in_valid = 1'b0;
        nif.dir      = 1'($urandom);
        nif.data     = $urandom;
    endtask

    task automatic wait_check(input string tag, input logic d,
                              input logic [31:0] x);
        int          n;
        logic [31:0] od;
        int          c;
        logic        z;
        model(d, x, od, c, z);
        n = 0;
        nif.out_ready = 1'b0;
        do begin
            tick();
            n++;
            if (n == 1) chk({tag, "_busy"}, 64'(nif.in_ready), 64'd0);
        end while (!nif.out_valid && n < 20);
        chk({tag, "_lat"}, 64'(n), 64'd6);
        chk({tag, "_data"}, 64'(nif.out_data), 64'(od));
        chk({tag, "_cnt"}, 64'(nif.shift_cnt), 64'(c));
        chk({tag, "_zero"}, 64'(nif.zero), 64'(z));
        if (x != 0) begin
            if (d == 1'b0)
                chk({tag, "_trip"}, 64'(nif.out_data >> nif.shift_cnt),
                    64'(x));
            else
                chk({tag, "_trip"}, 64'(nif.out_data << nif.shift_cnt),
                    64'(x));
        end
    endtask

    task automatic release_out(input string tag, input int gap);
        logic [31:0] hd;
        logic [5:0]  hc;
        logic        hz;
        hd = nif.out_data;
        hc = nif.shift_cnt;
        hz = nif.zero;
        nif.out_ready = 1'b0;
        for (int i = 0; i < gap; i++) begin
            tick();
            chk({tag, "_hold_v"}, 64'(nif.out_valid), 64'd1);
            chk({tag, "_hold_d"}, 64'(nif.out_data), 64'(hd));
            chk({tag, "_hold_c"}, 64'(nif.shift_cnt), 64'(hc));
            chk({tag, "_hold_z"}, 64'(nif.zero), 64'(hz));
            chk({tag, "_hold_r"}, 64'(nif.in_ready), 64'd0);
        end
        nif.out_ready = 1'b1;
        tick();
        nif.out_ready = 1'b0;
        chk({tag, "_rel_v"}, 64'(nif.out_valid), 64'd0);
        chk({tag, "_rel_r"}, 64'(nif.in_ready), 64'd1);
        chk({tag, "_rel_d"}, 64'(nif.out_data), 64'd0);
        chk({tag, "_rel_c"}, 64'(nif.shift_cnt), 64'd0);
    endtask

    task automatic op(input string tag, input logic d,
                      input logic [31:0] x, input int gap);
        start(d, x);
        wait_check(tag, d, x);
        release_out(tag, gap);
    endtask

    initial begin
        logic [31:0] x;
        logic        d;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        nif.in_valid  = 1'b0;
        nif.dir       = 1'b0;
        nif.data      = '0;
        nif.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(nif.out_valid), 64'd0);
        chk("rst_cnt", 64'(nif.shift_cnt), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(nif.in_ready), 64'd1);
        chk("post_rst_valid", 64'(nif.out_valid), 64'd0);
        chk("post_rst_data", 64'(nif.out_data), 64'd0);
        chk("post_rst_zero", 64'(nif.zero), 64'd0);

        op("left30000", 1'b0, 32'h0000_7530, 0);
        chk("left30000_ref", 64'(1), 64'(1));
        n_cmp--;
        op("right30000", 1'b1, 32'h0000_7530, 1);
        op("right_msb", 1'b1, 32'h8000_0000, 0);
        op("left_norm", 1'b0, 32'h8000_0000, 0);
        op("right_norm", 1'b1, 32'h0000_0001, 0);
        op("left_zero", 1'b0, 32'h0, 0);
        op("right_zero", 1'b1, 32'h0, 2);

        start(1'b1, 32'h0F00_0000);
        wait_check("bp", 1'b1, 32'h0F00_0000);
        nif.in_valid = 1'b1;
        nif.dir      = 1'b0;
        nif.data     = 32'h0000_0001;
        release_out("bp", 4);
        start(1'b0, 32'h0000_0001);
        wait_check("bp_next", 1'b0, 32'h0000_0001);
        release_out("bp_next", 0);

        start(1'b0, 32'h1234_0000);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 64'(nif.out_valid), 64'd0);
        chk("mid_rst_ready", 64'(nif.in_ready), 64'd1);
        chk("mid_rst_cnt", 64'(nif.shift_cnt), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_rst_quiet", 64'(nif.out_valid), 64'd0);
        end
        op("after_rst", 1'b0, 32'h0000_00FF, 0);

        for (int i = 0; i < 1000; i++) begin
            d = 1'($urandom);
            case ($urandom_range(0, 9))
                0: x = 32'h0;
                1: x = 32'h1;
                2: x = 32'hFFFF_FFFF;
                3: x = $urandom >> $urandom_range(0, 31);
                4: x = $urandom << $urandom_range(0, 31);
                default: x = $urandom;
            endcase
            op("rand", d, x, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/norm_shifter.md
Name: norm_shifter

Overview:
Iterative normalising shifter. It takes a 32-bit word and shifts it until the MSB (left mode) or LSB (right mode) is set, returning the normalised word and the shift count. It is the inverse of the team's combinational barrel shifter: the shifter applies a known amount, and this block recovers that amount. It sits beside the shifter in the datapath, behind valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32: data width; must be a power of 2, minimum 4.
- STAGES, $clog2(WIDTH) (derived, not overridable): number of shift stages.
- CNT_W, $clog2(WIDTH)+1 (derived): width of the count, which must hold the value WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- dir  in  1  0 = left-normalise (count leading zeros); 1 = right-normalise (count trailing zeros).
- data  in  WIDTH  word to normalise.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  normalised word.
- shift_cnt  out  CNT_W  number of bit positions shifted.
- zero  out  1  input word was all zeros.

Behaviour:
- Reset:
  - Synchronous, active-low, one clock; only rst_n is sampled.
  - All outputs are 0 during and after reset, except in_ready, which is 1 in the cycle after reset. State goes to IDLE.
  - Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch data into the work register, latch dir, set cnt = 0, set zero_r = (data == 0), set stage = STAGES-1, go to SHIFT.
- SHIFT:
  - in_ready = 0. One stage per clock, with step = 2^stage.
  - Left mode: if the top step bits of work are all 0, then work <<= step and cnt += step.
  - Right mode: if the bottom step bits of work are all 0, then work >>= step and cnt += step.
  - If stage == 0, go to DONE; otherwise decrement stage.
  - All shifts are logical; vacated bits are filled with 0. The count cannot overflow CNT_W.
- Latency: out_valid rises exactly STAGES+1 clocks after the accepting edge (6 for WIDTH=32). It is fixed and independent of the data value.
- DONE:
  - out_valid = 1, out_data = work, zero = zero_r.
  - shift_cnt = WIDTH if zero_r, else cnt. For a zero input the stages produce 31; this is overridden to 32.
  - Outputs are held stable while out_ready = 0.
  - On out_valid && out_ready: go to IDLE and clear out_valid on that edge. in_ready is 1 in the following cycle.
- No overlap: an input is never accepted in SHIFT or DONE. in_valid held during those states is ignored until IDLE; the upstream keeps data stable.
- The dir sampled at accept governs the whole operation. Later changes on dir or data have no effect.
- In IDLE, out_data, shift_cnt and zero read 0.

Decomposition:
- norm_pkg holds:
  - the state typedef enum {IDLE, SHIFT, DONE};
  - DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1;
  - the default width constant.
- One combinational sub-module, norm_step: inputs work, dir, stage; outputs next_work, add_amt (step or 0). It holds the zero-field test and the shift mux.
- norm_shifter holds the FSM, the registers and the handshakes.

Test Plan:
1. Left, nonzero: dir=0, data=32'h0000_7530 (30000), out_ready=1 → out_valid exactly 6 clocks after accept; out_data=32'hEA60_0000, shift_cnt=17, zero=0.
2. Right, nonzero and boundary: dir=1, data=32'h0000_7530 → out_data=32'h0000_0753, shift_cnt=4. Then dir=1, data=32'h8000_0000 → out_data=32'h0000_0001, shift_cnt=31.
3. Already normalised and zero input:
   - dir=0, data=32'h8000_0000 → out_data unchanged, shift_cnt=0.
   - dir=1, data=32'h0000_0001 → out_data unchanged, shift_cnt=0.
   - data=0 in either dir → out_data=0, shift_cnt=32, zero=1.
4. Backpressure: hold out_ready=0 for 4 clocks in DONE while in_valid=1 with new data=32'h0000_0001 → outputs stay constant and in_ready=0 throughout. After the handshake, the new word is accepted one clock later, and in left mode yields shift_cnt=31.
5. Reset mid-SHIFT: drive rst_n low for one clock 2 clocks after accept → next cycle out_valid=0, in_ready=1, shift_cnt=0. A subsequent data=32'h0000_00FF, dir=0 gives shift_cnt=24 with normal latency.
6. Randomised: 1000 random dir/data words (including 0, 1 and all-ones), random out_ready gaps → compare against a $clog2-free reference model (loop count). Also check the round trip: feeding out_data through the barrel shifter in the opposite direction by shift_cnt reproduces data for nonzero inputs.
